// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave bridge in front of a 4 KB dual-bank DFFRAM macro.
// Optional error response on window misses when WB_RAM_BRIDGE_ERR_EN is defined.
module wb_ram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
`ifdef WB_RAM_BRIDGE_ERR_EN
    output logic        wbs_err_o,
`endif
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [9:0]  ram_a,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do
);

`ifdef WB_RAM_BRIDGE_ERR_EN
    typedef enum logic [1:0] {StIdle, StRdWait, StAck, StErr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRdWait, StAck} state_e;
`endif

    state_e state_q;
    logic   req;
    logic   in_window;
    logic   hit;
    logic   start;
    logic   unused_adr;

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign in_window = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign hit       = req & in_window;
    assign unused_adr = ^wbs_adr_i[1:0];

    // RAM strobes are combinational so the macro samples them on the request edge.
    assign start  = ~wb_rst_i & (state_q == StIdle) & hit;
    assign ram_en = start;
    assign ram_we = (start & wbs_we_i) ? wbs_sel_i : 4'h0;
    assign ram_a  = wbs_adr_i[11:2];
    assign ram_di = wbs_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
`ifdef WB_RAM_BRIDGE_ERR_EN
            wbs_err_o <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
`ifdef WB_RAM_BRIDGE_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        if (wbs_we_i) begin
                            state_q   <= StAck;
                            wbs_ack_o <= 1'b1;
                        end else begin
                            state_q <= StRdWait;
                        end
                    end
`ifdef WB_RAM_BRIDGE_ERR_EN
                    else if (req) begin
                        state_q   <= StErr;
                        wbs_err_o <= 1'b1;
                    end
`endif
                end
                StRdWait: begin
                    // A dropped cycle discards the read without touching wbs_dat_o.
                    if (wbs_cyc_i) begin
                        wbs_dat_o <= ram_do;
                        wbs_ack_o <= 1'b1;
                        state_q   <= StAck;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAck: state_q <= StIdle;
`ifdef WB_RAM_BRIDGE_ERR_EN
                StErr: state_q <= StIdle;
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
